// File: rtl/crv_pkg.sv
// Shared constants for the vehicle-lane generator: per-level load patterns,
// lane direction type and the LFSR seed/taps used when CRV_LFSR_EN is defined.
package crv_pkg;

  typedef enum logic {DIR_LEFT, DIR_RIGHT} dir_e;

  localparam int unsigned PAT_LEVELS = 4;
  localparam int unsigned PAT_MAX_W  = 64;

  // Length of the vehicle run per level; right lanes park it at the MSB edge,
  // left lanes at the LSB edge (8-bit view: C0/E0/F0/F8 and 00/03/07/0F).
  localparam int unsigned RUN_R [PAT_LEVELS] = '{2, 3, 4, 5};
  localparam int unsigned RUN_L [PAT_LEVELS] = '{0, 2, 3, 4};

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef logic [PAT_MAX_W-1:0] pat_t;

  function automatic pat_t ones_low(int unsigned n);
    if (n == 0) return '0;
    return ~pat_t'(0) >> (PAT_MAX_W - n);
  endfunction

  function automatic int unsigned lvl_idx(int unsigned lvl);
    return (lvl >= PAT_LEVELS) ? PAT_LEVELS - 1 : lvl;
  endfunction

  function automatic pat_t pat_r(int unsigned lvl, int unsigned w);
    int unsigned r;
    r = RUN_R[lvl_idx(lvl)];
    if (r > w) r = w;
    return ones_low(r) << (w - r);
  endfunction

  function automatic pat_t pat_l(int unsigned lvl, int unsigned w);
    int unsigned r;
    r = RUN_L[lvl_idx(lvl)];
    if (r > w) r = w;
    return ones_low(r);
  endfunction

endpackage

// File: rtl/carril_vehiculo.sv
// One vehicle lane: rotating register, speed counter and registered wrap pulse.
// A zero counter marks a lane that has never been loaded and therefore stays idle.
module carril_vehiculo
  import crv_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 4,
  parameter dir_e        DIR       = DIR_LEFT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WIDTH-1:0]     load_pat,
  input  logic [CNT_WIDTH-1:0] period,
  input  logic                 step,
  input  logic                 inject,
  output logic [WIDTH-1:0]     lane,
  output logic                 wrap
);

  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 out_bit;
  logic [WIDTH-1:0]     rotated;

  always_comb begin
    if (DIR == DIR_RIGHT) begin
      out_bit = lane[0];
      rotated = {out_bit | inject, lane[WIDTH-1:1]};
    end else begin
      out_bit = lane[WIDTH-1];
      rotated = {lane[WIDTH-2:0], out_bit | inject};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane  <= '0;
      cnt_q <= '0;
      wrap  <= 1'b0;
    end else if (load) begin
      lane  <= load_pat;
      cnt_q <= period;
      wrap  <= 1'b0;
    end else if (step && cnt_q != '0) begin
      if (cnt_q == CNT_WIDTH'(1)) begin
        cnt_q <= period;
        lane  <= rotated;
        wrap  <= out_bit;
      end else begin
        cnt_q <= cnt_q - CNT_WIDTH'(1);
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: rtl/carriles_vehiculos.sv
// Parametrised vehicle-lane generator: level latch, per-lane rotators and frog collision.
// Define CRV_LFSR_EN to add LFSR-driven random traffic on each lane move.
module carriles_vehiculos
  import crv_pkg::*;
#(
  parameter int unsigned               NUM_LANES   = 6,
  parameter int unsigned               WIDTH       = 8,
  parameter int unsigned               NVL_WIDTH   = 2,
  parameter logic [NUM_LANES-1:0]      DIR_MASK    = 6'b101010,
  parameter logic [4*NUM_LANES-1:0]    PERIOD_BASE = {6{4'd8}},
  parameter int unsigned               CNT_WIDTH   = 4
) (
  input  logic                             CRV_CLOCK,
  input  logic                             CRV_RESET,
  input  logic [NVL_WIDTH-1:0]             CRV_NV_IN,
  input  logic                             CRV_CN_IN,
  input  logic                             CRV_TICK_IN,
  input  logic                             CRV_PAUSE_IN,
  input  logic [$clog2(NUM_LANES+1)-1:0]   CRV_FROG_LANE_IN,
  input  logic [$clog2(WIDTH)-1:0]         CRV_FROG_COL_IN,
  output logic [NUM_LANES*WIDTH-1:0]       CRV_LANES_OUT,
  output logic [NUM_LANES-1:0]             CRV_WRAP_OUT,
  output logic                             CRV_HIT_OUT,
  output logic [NVL_WIDTH-1:0]             CRV_LEVEL_OUT
);

  localparam int unsigned DW = CNT_WIDTH + 1;

  logic [NVL_WIDTH-1:0] level_q;
  logic [NVL_WIDTH-1:0] lvl_sel;
  logic                 step;
  logic [WIDTH-1:0]     lanes [NUM_LANES];
  logic [NUM_LANES-1:0] inject;
  logic                 hit_d;
  logic                 hit_q;

  // Counters reload with the period of the level taking effect this cycle.
  assign lvl_sel = CRV_CN_IN ? CRV_NV_IN : level_q;
  assign step    = CRV_TICK_IN & ~CRV_PAUSE_IN & ~CRV_CN_IN;

  always_ff @(posedge CRV_CLOCK or negedge CRV_RESET) begin
    if (!CRV_RESET)     level_q <= '0;
    else if (CRV_CN_IN) level_q <= CRV_NV_IN;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam dir_e LANE_DIR = DIR_MASK[i] ? DIR_RIGHT : DIR_LEFT;

    logic [DW-1:0]        diff;
    logic [CNT_WIDTH-1:0] period;
    logic [WIDTH-1:0]     pat;

    always_comb begin
      diff   = DW'(PERIOD_BASE[4*i +: 4]) - DW'(lvl_sel);
      period = (diff[DW-1] || diff == '0) ? CNT_WIDTH'(1) : diff[CNT_WIDTH-1:0];
      pat    = (LANE_DIR == DIR_RIGHT) ? WIDTH'(pat_r(32'(CRV_NV_IN), WIDTH))
                                       : WIDTH'(pat_l(32'(CRV_NV_IN), WIDTH));
    end

    carril_vehiculo #(
      .WIDTH     (WIDTH),
      .CNT_WIDTH (CNT_WIDTH),
      .DIR       (LANE_DIR)
    ) u_lane (
      .clk      (CRV_CLOCK),
      .rst_n    (CRV_RESET),
      .load     (CRV_CN_IN),
      .load_pat (pat),
      .period   (period),
      .step     (step),
      .inject   (inject[i]),
      .lane     (lanes[i]),
      .wrap     (CRV_WRAP_OUT[i])
    );

    assign CRV_LANES_OUT[WIDTH*i +: WIDTH] = lanes[i];
  end

`ifdef CRV_LFSR_EN
  logic [7:0] lfsr_q;

  always_ff @(posedge CRV_CLOCK or negedge CRV_RESET) begin
    if (!CRV_RESET)     lfsr_q <= LFSR_SEED;
    else if (CRV_CN_IN) lfsr_q <= LFSR_SEED;
    else if (step)      lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
  end

  // Each lane looks at the shared LFSR rotated by its index.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_inj
    logic [2:0] fld;
    assign fld       = 3'({lfsr_q, lfsr_q} >> (i % 8));
    assign inject[i] = 32'(fld) < (32'(level_q) + 32'd1);
  end
`else
  assign inject = '0;
`endif

  always_comb begin
    hit_d = 1'b0;
    if (32'(CRV_FROG_LANE_IN) < NUM_LANES && 32'(CRV_FROG_COL_IN) < WIDTH)
      hit_d = lanes[CRV_FROG_LANE_IN][CRV_FROG_COL_IN];
  end

  always_ff @(posedge CRV_CLOCK or negedge CRV_RESET) begin
    if (!CRV_RESET) hit_q <= 1'b0;
    else            hit_q <= hit_d;
  end

  assign CRV_HIT_OUT   = hit_q;
  assign CRV_LEVEL_OUT = level_q;

endmodule
